hazard_controller: RTL and testbench
====================================

// Module: hazard_controller
// PURPOSE
// - Pipeline sequencer for the 5-stage core; drives stall/flush/forward controls for every stage register, incl. EX/MEM hold.
// - Resolves EX operand forwarding, load-use stalls and taken-branch flushes.
// - Freezes the pipe while data memory is not ready; halts the core on a memory timeout.
// PARAMETERS
// - MEM_TIMEOUT  16  max consecutive not-ready cycles for one MEM access before HALT (>=2)
// - CNT_W        32  width of performance counters
// PORTS
// - clk               in   1  core clock; all state updates on negedge clk (same edge as pipeline registers)
// - rst_n             in   1  asynchronous active-low reset
// - rs1_d, rs2_d      in   5  source regs of instruction in DECODE
// - rs1_ex, rs2_ex    in   5  source regs of instruction in EXECUTE
// - rd_ex             in   5  dest reg in EXECUTE
// - result_src_ex     in   2  result select in EXECUTE; 2'b01 = load
// - pc_src_ex         in   1  taken branch/jump resolved in EXECUTE
// - rd_mem            in   5  dest reg in MEM
// - register_write_mem in  1  MEM instruction writes rd
// - result_src_mem    in   2  result select in MEM; 2'b01 = load
// - mem_write_enable_mem in 1 MEM instruction is a store
// - dmem_ready        in   1  data memory completes current access this cycle
// - rd_wb             in   5  dest reg in WRITEBACK
// - register_write_wb in   1  WB instruction writes rd
// - stall_f, stall_d, stall_e, stall_m out 1  hold PC / IF-ID / ID-EX / EX-MEM registers
// - flush_d, flush_e, flush_w out 1  bubble into IF-ID / ID-EX / MEM-WB
// - forward_a_ex, forward_b_ex out 2  00 regfile, 01 WB result, 10 MEM alu_result
// - halted            out  1  sticky; memory timeout occurred
// - stall_cycles, flush_count out CNT_W  perf counters (see CONFIGURATION)
// BEHAVIOUR
// - State (registered, negedge clk): RUN, MEM_WAIT, HALT; wait_cnt ($clog2(MEM_TIMEOUT) bits).
// - Reset (rst_n=0, async): state=RUN, wait_cnt=0, halted=0, counters=0; while low: flush_d=flush_e=1, all stalls/flush_w=0.
// - Forwarding (comb, per operand, priority MEM>WB): 10 if register_write_mem && rd_mem!=0 && rd_mem==rs; else 01 if register_write_wb && rd_wb!=0 && rd_wb==rs; else 00.
// - mem_req_m = mem_write_enable_mem | (result_src_mem==2'b01); mem_busy = mem_req_m & ~dmem_ready.
// - lw_stall = (result_src_ex==2'b01) && rd_ex!=0 && (rd_ex==rs1_d || rd_ex==rs2_d).
// - Output priority (comb): HALT > mem_busy > pc_src_ex > lw_stall.
// - HALT or mem_busy: stall_f/d/e/m=1, flush_w=1, flush_d=flush_e=0 (branch held, acted on after release).
// - else pc_src_ex: flush_d=flush_e=1, no stalls (lw_stall suppressed; D instruction is squashed).
// - else lw_stall: stall_f=stall_d=1, flush_e=1 for exactly one cycle.
// - FSM: RUN->MEM_WAIT on mem_busy (wait_cnt<=1); MEM_WAIT: dmem_ready->RUN, wait_cnt<=0;
//   else wait_cnt+1; when wait_cnt==MEM_TIMEOUT-1 and still busy -> HALT, halted<=1.
// - HALT exits only via reset; all inputs ignored. Reset mid-MEM_WAIT abandons access, returns to RUN.
// - mem_busy with dmem_ready=1 in first cycle: no stall, state stays RUN.
// CONFIGURATION
// - Macro HAZARD_PERF_CNT_EN defined: stall_cycles +1 every cycle any stall_* asserted;
//   flush_count +1 every cycle flush_e asserted outside reset; both wrap at 2**CNT_W.
// - Not defined: counter logic removed, stall_cycles/flush_count tied to 0.
// STRUCTURE
// - hazard_pkg: typedef enum {RUN, MEM_WAIT, HALT} hz_state_t; FWD_NONE=2'b00, FWD_WB=2'b01,
//   FWD_MEM=2'b10; RESULT_SRC_LOAD=2'b01.
// - Sub-module forward_select (comb): one instance per EX operand (A, B).
// TESTING
// - rd_mem=5,register_write_mem=1,rd_wb=5,register_write_wb=1,rs1_ex=5 -> forward_a_ex=10; rd_mem=0 -> 01; rs1_ex=0 -> 00.
// - load in EX rd_ex=7, rs2_d=7 -> 1 cycle stall_f=stall_d=flush_e=1, then all 0 next cycle.
// - load-use plus pc_src_ex=1 same cycle -> flush_d=flush_e=1, stall_f=stall_d=0.
// - store in MEM, dmem_ready low 3 cycles -> stall_f/d/e/m=flush_w=1 for 3 cycles, 0 on 4th; pending pc_src_ex flushes after release.
// - dmem_ready held low, MEM_TIMEOUT=16 -> halted=1 after 16 busy cycles, stalls stay 1; rst_n pulse -> halted=0, RUN.
// - HAZARD_PERF_CNT_EN: 3 load-use stalls + 2 branches -> stall_cycles=3, flush_count=5; undefined -> both 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
// Stateless: holds only constants and the sequencer state enum.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_NONE        = 2'b00;
    localparam logic [1:0] FWD_WB          = 2'b01;
    localparam logic [1:0] FWD_MEM         = 2'b10;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/forward_select.sv
// EX operand forwarding select for one source register, MEM result preferred over WB.
// Latency: combinational. Backpressure: none, pure decode.
module forward_select
    import hazard_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] rd_mem_i,
    input  logic       reg_write_mem_i,
    input  logic [4:0] rd_wb_i,
    input  logic       reg_write_wb_i,
    output logic [1:0] fwd_o
);

    always_comb begin
        fwd_o = FWD_NONE;
        if (reg_write_mem_i && (rd_mem_i != 5'd0) && (rd_mem_i == rs_i)) begin
            fwd_o = FWD_MEM;
        end else if (reg_write_wb_i && (rd_wb_i != 5'd0) && (rd_wb_i == rs_i)) begin
            fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/forward sequencer for the 5-stage core; state updates on negedge clk.
// Latency: controls are combinational from current state; freezes all stages while dmem is busy.
// Optional perf counters built only when HAZARD_PERF_CNT_EN is defined; otherwise tied to 0.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_ex,
    input  logic [4:0]       rs2_ex,
    input  logic [4:0]       rd_ex,
    input  logic [1:0]       result_src_ex,
    input  logic             pc_src_ex,
    input  logic [4:0]       rd_mem,
    input  logic             register_write_mem,
    input  logic [1:0]       result_src_mem,
    input  logic             mem_write_enable_mem,
    input  logic             dmem_ready,
    input  logic [4:0]       rd_wb,
    input  logic             register_write_wb,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic [1:0]       forward_a_ex,
    output logic [1:0]       forward_b_ex,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    hz_state_t         state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              halted_q, halted_d;

    logic mem_req_m, mem_busy, lw_stall;

    forward_select u_fwd_a (
        .rs_i            (rs1_ex),
        .rd_mem_i        (rd_mem),
        .reg_write_mem_i (register_write_mem),
        .rd_wb_i         (rd_wb),
        .reg_write_wb_i  (register_write_wb),
        .fwd_o           (forward_a_ex)
    );

    forward_select u_fwd_b (
        .rs_i            (rs2_ex),
        .rd_mem_i        (rd_mem),
        .reg_write_mem_i (register_write_mem),
        .rd_wb_i         (rd_wb),
        .reg_write_wb_i  (register_write_wb),
        .fwd_o           (forward_b_ex)
    );

    assign mem_req_m = mem_write_enable_mem | (result_src_mem == RESULT_SRC_LOAD);
    assign mem_busy  = mem_req_m & ~dmem_ready;
    assign lw_stall  = (result_src_ex == RESULT_SRC_LOAD) && (rd_ex != 5'd0) &&
                       ((rd_ex == rs1_d) || (rd_ex == rs2_d));
    assign halted    = halted_q;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            halted_q   <= halted_d;
        end
    end

    // The RUN cycle that first sees busy counts as wait #1 toward the timeout.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        halted_d   = halted_q;
        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!mem_busy) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    // A taken branch seen during a freeze is not lost: EX is held, so it re-presents on release.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (!rst_n) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if ((state_q == HALT) || mem_busy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (pc_src_ex) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (stall_f | stall_d | stall_e | stall_m) begin
                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            end
            if (flush_e) begin
                flush_count_q <= flush_count_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: expected controls queued at drive time, popped at sample time.
module tb_hazard_controller;

    typedef struct packed {
        logic [4:0] rs1_d, rs2_d, rs1_ex, rs2_ex, rd_ex;
        logic [1:0] rsrc_ex;
        logic       pc_src;
        logic [4:0] rd_mem;
        logic       rw_mem;
        logic [1:0] rsrc_mem;
        logic       we_mem;
        logic       ready;
        logic [4:0] rd_wb;
        logic       rw_wb;
    } stim_t;

    // stall = {f,d,e,m}, flush = {d,e,w}
    typedef struct packed {
        logic [3:0] stall;
        logic [2:0] flush;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       halted;
    } exp_t;

    logic        clk, rst_n;
    logic [4:0]  rs1_d, rs2_d, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic [1:0]  result_src_ex, result_src_mem;
    logic        pc_src_ex, register_write_mem, mem_write_enable_mem, dmem_ready, register_write_wb;
    logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, halted;
    logic [1:0]  forward_a_ex, forward_b_ex;
    logic [31:0] stall_cycles, flush_count;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    hazard_controller #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .rs1_d                (rs1_d),
        .rs2_d                (rs2_d),
        .rs1_ex               (rs1_ex),
        .rs2_ex               (rs2_ex),
        .rd_ex                (rd_ex),
        .result_src_ex        (result_src_ex),
        .pc_src_ex            (pc_src_ex),
        .rd_mem               (rd_mem),
        .register_write_mem   (register_write_mem),
        .result_src_mem       (result_src_mem),
        .mem_write_enable_mem (mem_write_enable_mem),
        .dmem_ready           (dmem_ready),
        .rd_wb                (rd_wb),
        .register_write_wb    (register_write_wb),
        .stall_f              (stall_f),
        .stall_d              (stall_d),
        .stall_e              (stall_e),
        .stall_m              (stall_m),
        .flush_d              (flush_d),
        .flush_e              (flush_e),
        .flush_w              (flush_w),
        .forward_a_ex         (forward_a_ex),
        .forward_b_ex         (forward_b_ex),
        .halted               (halted),
        .stall_cycles         (stall_cycles),
        .flush_count          (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.ready = 1'b1;
        return s;
    endfunction

    function automatic exp_t ex(logic [3:0] st, logic [2:0] fl, logic [1:0] fa, logic [1:0] fb, logic h);
        exp_t e;
        e.stall  = st;
        e.flush  = fl;
        e.fa     = fa;
        e.fb     = fb;
        e.halted = h;
        return e;
    endfunction

    // Inputs change on posedge (away from the negedge state update); outputs sampled 1ns later.
    task automatic step(input string tag, input logic rst, input stim_t s, input exp_t e);
        exp_t  got, want;
        string t;
        @(posedge clk);
        rst_n                = rst;
        rs1_d                = s.rs1_d;
        rs2_d                = s.rs2_d;
        rs1_ex               = s.rs1_ex;
        rs2_ex               = s.rs2_ex;
        rd_ex                = s.rd_ex;
        result_src_ex        = s.rsrc_ex;
        pc_src_ex            = s.pc_src;
        rd_mem               = s.rd_mem;
        register_write_mem   = s.rw_mem;
        result_src_mem       = s.rsrc_mem;
        mem_write_enable_mem = s.we_mem;
        dmem_ready           = s.ready;
        rd_wb                = s.rd_wb;
        register_write_wb    = s.rw_wb;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1;
        got  = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
                forward_a_ex, forward_b_ex, halted};
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        chk(t, {20'b0, got}, {20'b0, want});
    endtask

    initial begin
        stim_t s, lu, br;
        exp_t  e_idle, e_frz, e_frz_h, e_lu, e_br, e_rst;
        logic [31:0] exp_st, exp_fl;

        e_idle  = ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        e_frz   = ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
        e_frz_h = ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b1);
        e_lu    = ex(4'b1100, 3'b010, 2'b00, 2'b00, 1'b0);
        e_br    = ex(4'b0000, 3'b110, 2'b00, 2'b00, 1'b0);
        e_rst   = ex(4'b0000, 3'b110, 2'b00, 2'b00, 1'b0);

        lu = idle(); lu.rsrc_ex = 2'b01; lu.rd_ex = 5'd7; lu.rs2_d = 5'd7;
        br = idle(); br.pc_src = 1'b1;

        rst_n = 1'b0;
        step("reset", 1'b0, idle(), e_rst);
        chk("rst_stall_cnt", stall_cycles, 32'd0);
        chk("rst_flush_cnt", flush_count, 32'd0);
        step("idle", 1'b1, idle(), e_idle);

        s = idle(); s.rd_mem = 5'd5; s.rw_mem = 1'b1; s.rd_wb = 5'd5; s.rw_wb = 1'b1; s.rs1_ex = 5'd5;
        step("fwd_mem_prio", 1'b1, s, ex(4'b0000, 3'b000, 2'b10, 2'b00, 1'b0));
        s.rd_mem = 5'd0;
        step("fwd_wb", 1'b1, s, ex(4'b0000, 3'b000, 2'b01, 2'b00, 1'b0));
        s.rs1_ex = 5'd0; s.rs2_ex = 5'd5; s.rd_mem = 5'd5;
        step("fwd_x0_b_mem", 1'b1, s, ex(4'b0000, 3'b000, 2'b00, 2'b10, 1'b0));
        s = idle(); s.rd_mem = 5'd9; s.rd_wb = 5'd9; s.rs1_ex = 5'd9; s.rs2_ex = 5'd9;
        step("fwd_no_write", 1'b1, s, e_idle);

        step("load_use", 1'b1, lu, e_lu);
        step("load_use_after", 1'b1, idle(), e_idle);
        s = idle(); s.rsrc_ex = 2'b01; s.rd_ex = 5'd0;
        step("load_rd0", 1'b1, s, e_idle);
        s = lu; s.pc_src = 1'b1;
        step("lu_plus_branch", 1'b1, s, e_br);

        s = idle(); s.we_mem = 1'b1; s.ready = 1'b0; s.pc_src = 1'b1;
        for (int i = 1; i <= 3; i++) step($sformatf("store_wait%0d", i), 1'b1, s, e_frz);
        s.ready = 1'b1;
        step("store_release_br", 1'b1, s, e_br);
        step("post_release", 1'b1, idle(), e_idle);
        s = idle(); s.rsrc_mem = 2'b01;
        step("load_ready_first", 1'b1, s, e_idle);

        s = idle(); s.rsrc_mem = 2'b01; s.ready = 1'b0;
        for (int i = 1; i <= 16; i++) step($sformatf("busy%0d", i), 1'b1, s, e_frz);
        step("halted", 1'b1, br, e_frz_h);
        step("halted_hold", 1'b1, lu, e_frz_h);

        step("halt_reset", 1'b0, idle(), e_rst);
        step("after_reset", 1'b1, idle(), e_idle);
        step("run_load_use", 1'b1, lu, e_lu);

        step("cnt_reset", 1'b0, idle(), e_rst);
        step("cnt_idle", 1'b1, idle(), e_idle);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("cnt_lu%0d", i), 1'b1, lu, e_lu);
            step($sformatf("cnt_gap%0d", i), 1'b1, idle(), e_idle);
        end
        step("cnt_br0", 1'b1, br, e_br);
        step("cnt_br1", 1'b1, br, e_br);
        step("cnt_end", 1'b1, idle(), e_idle);
`ifdef HAZARD_PERF_CNT_EN
        exp_st = 32'd3;
        exp_fl = 32'd5;
`else
        exp_st = 32'd0;
        exp_fl = 32'd0;
`endif
        chk("stall_cycles", stall_cycles, exp_st);
        chk("flush_count", flush_count, exp_fl);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
